cci_mpf_c0_rd_throttle: RTL and testbench



---
 rtl/cci_mpf_c0_rd_throttle.sv | 129 ++++++++++++
 tb/tb_cci_mpf_c0_rd_throttle.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_c0_rd_throttle.sv
// C0 read-request throttle: buffers AFU reads and issues them to QLP while QLP has room
// and in-flight reads are under MAX_OUTSTANDING. CCI_MPF_RD_THROTTLE_STATS_EN adds stall counters.
module cci_mpf_c0_rd_throttle #(
   parameter int CCI_TX_HDR_WIDTH = 61,
   parameter int FIFO_DEPTH       = 8,
   parameter int ALMFULL_SLACK    = 2,
   parameter int MAX_OUTSTANDING  = 64
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [CCI_TX_HDR_WIDTH-1:0]            afu_C0TxHdr,
   input  logic                                   afu_C0TxRdValid,
   output logic                                   afu_C0TxAlmFull,
   output logic [CCI_TX_HDR_WIDTH-1:0]            qlp_C0TxHdr,
   output logic                                   qlp_C0TxRdValid,
   input  logic                                   qlp_C0TxAlmFull,
   input  logic                                   qlp_C0RxRdValid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   err_overflow,
   output logic                                   err_underflow
`ifdef CCI_MPF_RD_THROTTLE_STATS_EN
   ,
   output logic [31:0]                            stat_limit_stall,
   output logic [31:0]                            stat_qlp_stall
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ALM_THRESH = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);
   localparam logic [OUT_W-1:0] MAX_C      = OUT_W'(MAX_OUTSTANDING);

   logic [CCI_TX_HDR_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [CNT_W-1:0]            count;
   logic [CNT_W-1:0]            count_next;
   logic                        alm_q;
   logic                        fifo_empty;
   logic                        fifo_full;
   logic                        below_limit;
   logic                        issue;
   logic                        push;
   logic                        drop;

   always_comb begin
      fifo_empty  = (count == '0);
      fifo_full   = (count == DEPTH_C);
      below_limit = (outstanding < MAX_C);
      // A response in the same cycle frees a slot, so issue is allowed even at the limit.
      issue       = !fifo_empty && !qlp_C0TxAlmFull && (below_limit || qlp_C0RxRdValid);
      push        = afu_C0TxRdValid && (!fifo_full || issue);
      drop        = afu_C0TxRdValid && fifo_full && !issue;
      count_next  = count;
      if (push && !issue)
         count_next = count + CNT_W'(1);
      else if (!push && issue)
         count_next = count - CNT_W'(1);
   end

   // Held high combinationally during reset so the AFU never sees a window to issue.
   assign afu_C0TxAlmFull = alm_q | reset;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= afu_C0TxHdr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         alm_q           <= 1'b0;
         outstanding     <= '0;
         qlp_C0TxRdValid <= 1'b0;
         qlp_C0TxHdr     <= '0;
         err_overflow    <= 1'b0;
         err_underflow   <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (issue)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count           <= count_next;
         alm_q           <= (count_next >= ALM_THRESH);
         qlp_C0TxRdValid <= issue;
         if (issue)
            qlp_C0TxHdr <= mem[rd_ptr];

         if (issue && !qlp_C0RxRdValid) begin
            outstanding <= outstanding + OUT_W'(1);
         end else if (!issue && qlp_C0RxRdValid) begin
            if (outstanding != '0)
               outstanding <= outstanding - OUT_W'(1);
            else
               err_underflow <= 1'b1;
         end

         if (drop)
            err_overflow <= 1'b1;
      end
   end

`ifdef CCI_MPF_RD_THROTTLE_STATS_EN
   logic limit_block;
   logic qlp_block;

   always_comb begin
      limit_block = !fifo_empty && !qlp_C0TxAlmFull && !below_limit && !qlp_C0RxRdValid;
      qlp_block   = !fifo_empty && qlp_C0TxAlmFull;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_limit_stall <= '0;
         stat_qlp_stall   <= '0;
      end else begin
         if (limit_block && (stat_limit_stall != 32'hFFFF_FFFF))
            stat_limit_stall <= stat_limit_stall + 32'd1;
         if (qlp_block && (stat_qlp_stall != 32'hFFFF_FFFF))
            stat_qlp_stall <= stat_qlp_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cci_mpf_c0_rd_throttle.sv
// Bench for cci_mpf_c0_rd_throttle (MAX_OUTSTANDING=4): vector table for per-cycle
// expectations, scoreboard queue for issued header order, hand sequences for corner cases.
module tb_cci_mpf_c0_rd_throttle;

   localparam int HW    = 61;
   localparam int DEPTH = 8;
   localparam int SLACK = 2;
   localparam int MAXO  = 4;
   localparam int OW    = $clog2(MAXO + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [HW-1:0] afu_hdr = '0;
   logic          afu_vld = 1'b0;
   logic          afu_alm;
   logic [HW-1:0] qlp_hdr;
   logic          qlp_vld;
   logic          qlp_alm = 1'b0;
   logic          qlp_rsp = 1'b0;
   logic [OW-1:0] outstanding;
   logic          err_overflow;
   logic          err_underflow;

   cci_mpf_c0_rd_throttle #(
      .CCI_TX_HDR_WIDTH (HW),
      .FIFO_DEPTH       (DEPTH),
      .ALMFULL_SLACK    (SLACK),
      .MAX_OUTSTANDING  (MAXO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .afu_C0TxHdr     (afu_hdr),
      .afu_C0TxRdValid (afu_vld),
      .afu_C0TxAlmFull (afu_alm),
      .qlp_C0TxHdr     (qlp_hdr),
      .qlp_C0TxRdValid (qlp_vld),
      .qlp_C0TxAlmFull (qlp_alm),
      .qlp_C0RxRdValid (qlp_rsp),
      .outstanding     (outstanding),
      .err_overflow    (err_overflow),
      .err_underflow   (err_underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [HW-1:0] exp_q[$];
   logic [HW-1:0] exp_hdr;

   typedef struct {
      logic        vld;
      logic [15:0] hdr;
      logic        qalm;
      logic        rsp;
      logic        exp_qv;
      logic [2:0]  exp_out;
      logic        chk_out;
      logic        exp_uf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [15:0] h, input logic qa, input logic r,
                      input logic qv, input logic [2:0] o, input logic co, input logic uf);
      vec_t e;
      e.vld = v; e.hdr = h; e.qalm = qa; e.rsp = r;
      e.exp_qv = qv; e.exp_out = o; e.chk_out = co; e.exp_uf = uf;
      tbl.push_back(e);
   endtask

   // Drive one cycle of inputs, optionally record the header as expected at QLP,
   // then land 1 time unit after the edge so registered outputs are settled.
   task automatic cyc(input logic v, input logic [15:0] h, input logic qa, input logic r,
                      input bit sb);
      afu_vld = v;
      afu_hdr = HW'(h);
      qlp_alm = qa;
      qlp_rsp = r;
      if (sb) exp_q.push_back(HW'(h));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      afu_vld = 1'b0;
      qlp_alm = 1'b0;
      qlp_rsp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   // Scoreboard: every QLP issue must match the oldest accepted request.
   always @(negedge clk) begin
      if (qlp_vld === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got hdr 0x%0h, expected no issue", qlp_hdr);
         end else begin
            exp_hdr = exp_q.pop_front();
            if (qlp_hdr !== exp_hdr) begin
               n_err++;
               $display("FAIL sb_hdr: got 0x%0h, expected 0x%0h", qlp_hdr, exp_hdr);
            end
         end
      end
   end

   initial begin
      // basic path
      add(1, 16'h1234, 0, 0, 0, 0, 1, 0);
      add(0, 16'h0000, 0, 0, 1, 1, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 1, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 0, 1, 0);
      // outstanding limit
      add(1, 16'h0A01, 0, 0, 0, 0, 1, 0);
      add(1, 16'h0A02, 0, 0, 1, 1, 1, 0);
      add(1, 16'h0A03, 0, 0, 1, 2, 1, 0);
      add(1, 16'h0A04, 0, 0, 1, 3, 1, 0);
      add(1, 16'h0A05, 0, 0, 1, 4, 1, 0);
      add(1, 16'h0A06, 0, 0, 0, 4, 1, 0);
      add(0, 16'h0000, 0, 0, 0, 4, 1, 0);
      add(0, 16'h0000, 0, 1, 1, 4, 1, 0);
      add(0, 16'h0000, 0, 0, 0, 4, 1, 0);
      add(0, 16'h0000, 0, 1, 1, 4, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 3, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 2, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 1, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 0, 1, 0);
      // issue and response together at outstanding=3
      add(1, 16'h0B01, 0, 0, 0, 0, 1, 0);
      add(1, 16'h0B02, 0, 0, 1, 1, 1, 0);
      add(1, 16'h0B03, 0, 0, 1, 2, 1, 0);
      add(1, 16'h0B04, 0, 0, 1, 3, 1, 0);
      add(0, 16'h0000, 0, 1, 1, 3, 1, 0);
      add(0, 16'h0000, 0, 0, 0, 3, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 2, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 1, 1, 0);
      add(0, 16'h0000, 0, 1, 0, 0, 1, 0);
      // underflow, sticky
      add(0, 16'h0000, 0, 1, 0, 0, 1, 1);
      add(0, 16'h0000, 0, 0, 0, 0, 1, 1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_almfull", afu_alm, 1);
      chk("rst_qlp_vld", qlp_vld, 0);
      chk("rst_qlp_hdr", qlp_hdr, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_of", err_overflow, 0);
      chk("rst_err_uf", err_underflow, 0);
      reset = 1'b0;
      #1;
      chk("rst_release_almfull", afu_alm, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].vld, tbl[i].hdr, tbl[i].qalm, tbl[i].rsp, tbl[i].vld);
         chk($sformatf("vec%0d_qlp_vld", i), qlp_vld, tbl[i].exp_qv);
         if (tbl[i].chk_out)
            chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].exp_out);
         chk($sformatf("vec%0d_err_uf", i), err_underflow, tbl[i].exp_uf);
         chk($sformatf("vec%0d_almfull", i), afu_alm, 0);
      end
      chk("tbl_sb_drained", exp_q.size(), 0);

      // QLP backpressure, full FIFO, simultaneous push/pop when full, overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 16'h0C00 + 16'(i), 1, 0, 1);
         chk("bp_qlp_vld", qlp_vld, 0);
         if (i == 4) chk("bp_almfull_pre", afu_alm, 0);
         if (i == 5) chk("bp_almfull_rise", afu_alm, 1);
      end
      cyc(1, 16'h0C08, 0, 0, 1);
      chk("full_pushpop_vld", qlp_vld, 1);
      chk("full_pushpop_no_of", err_overflow, 0);
      chk("full_pushpop_almfull", afu_alm, 1);
      chk("full_pushpop_out", outstanding, 1);
      cyc(1, 16'h0C09, 1, 0, 0);
      chk("overflow_set", err_overflow, 1);
      chk("overflow_no_issue", qlp_vld, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 16'h0000, 0, 1, 0);
         chk("drain_vld", qlp_vld, 1);
         chk("drain_out", outstanding, 1);
         if (i == 1) chk("drain_almfull_hold", afu_alm, 1);
         if (i == 2) chk("drain_almfull_fall", afu_alm, 0);
      end
      cyc(0, 16'h0000, 0, 1, 0);
      chk("drain_last_out", outstanding, 0);
      repeat (3) cyc(0, 16'h0000, 0, 0, 0);
      chk("overflow_sticky", err_overflow, 1);
      chk("drain_no_uf", err_underflow, 0);
      chk("bp_sb_drained", exp_q.size(), 0);

      // reset mid-operation: 3 queued, 2 in flight, underflow flag set
      do_reset();
      cyc(0, 16'h0000, 0, 1, 0);
      chk("mid_uf_set", err_underflow, 1);
      cyc(1, 16'h0D00, 0, 0, 1);
      cyc(1, 16'h0D01, 0, 0, 1);
      cyc(1, 16'h0E00, 0, 0, 1);
      cyc(1, 16'h0E01, 1, 0, 1);
      cyc(1, 16'h0E02, 1, 0, 1);
      chk("mid_pre_out", outstanding, 2);
      chk("mid_pre_vld", qlp_vld, 0);
      reset = 1'b1;
      cyc(0, 16'h0000, 0, 0, 0);
      chk("mid_rst_out", outstanding, 0);
      chk("mid_rst_vld", qlp_vld, 0);
      chk("mid_rst_uf", err_underflow, 0);
      chk("mid_rst_of", err_overflow, 0);
      chk("mid_rst_almfull", afu_alm, 1);
      exp_q.delete();
      reset = 1'b0;
      #1;
      chk("mid_release_almfull", afu_alm, 0);
      repeat (3) cyc(0, 16'h0000, 0, 0, 0);
      chk("mid_post_out", outstanding, 0);
      cyc(1, 16'h0F00, 0, 0, 1);
      cyc(0, 16'h0000, 0, 0, 0);
      chk("mid_new_vld", qlp_vld, 1);
      chk("mid_new_hdr", qlp_hdr, 16'h0F00);
      cyc(0, 16'h0000, 0, 0, 0);
      chk("mid_sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
